// File: rtl/itcm_boot_loader.sv
// rtl/itcm_boot_loader.sv - boot-time ITCM image loader with trailing checksum
//
// Packs a little-endian byte stream into 32-bit words, writes them to ITCM
// word addresses 0, 4, 8, ... and verifies a trailing 8-bit additive checksum.
// The core is held in reset until the image is loaded and verified.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, load_len     load request pulse and word count sampled with it
//   s_valid/s_data      byte stream in; s_ready out, byte taken on valid & ready
//   itcm_cs/addr/wen/wdata  ITCM external port (owned while busy)
//   cpu_rst             core reset, released only after a verified load
//   busy/done/err       load status; done and err are sticky until next start
module itcm_boot_loader #(
    parameter int WORD_WTH     = 32,
    parameter int MEM_ADDR_WTH = 16,
    parameter int MASK_WTH     = 4,
    parameter int LEN_WTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WTH-1:0]      load_len,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    output logic                    s_ready,
    output logic                    itcm_cs,
    output logic [MEM_ADDR_WTH-1:0] itcm_addr,
    output logic [MASK_WTH-1:0]     itcm_wen,
    output logic [WORD_WTH-1:0]     itcm_wdata,
    output logic                    cpu_rst,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // Largest image that fits in the word-addressable ITCM.
    localparam int unsigned MAX_WORDS = 2 ** (MEM_ADDR_WTH - 2);

    state_t                  state_q, state_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [LEN_WTH-1:0]      word_cnt_q, word_cnt_d;
    logic [LEN_WTH-1:0]      len_q, len_d;
    logic [7:0]              csum_q, csum_d;
    logic                    s_ready_q, s_ready_d;
    logic                    cs_q, cs_d;
    logic [MEM_ADDR_WTH-1:0] addr_q, addr_d;
    logic [MASK_WTH-1:0]     wen_q, wen_d;
    logic [WORD_WTH-1:0]     wdata_q, wdata_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    len_bad;
    logic                    accept;
    logic [LEN_WTH-1:0]      word_cnt_inc;

    assign len_bad      = (load_len == '0) || (32'(load_len) > MAX_WORDS);
    assign accept       = s_valid && s_ready_q;
    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            s_ready_q  <= 1'b0;
            cs_q       <= 1'b0;
            addr_q     <= '0;
            wen_q      <= '0;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            s_ready_q  <= s_ready_d;
            cs_q       <= cs_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        csum_d     = csum_q;
        s_ready_d  = s_ready_q;
        cs_d       = cs_q;
        addr_d     = addr_q;
        wen_d      = '0;
        wdata_d    = wdata_q;
        cpu_rst_d  = cpu_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    if (len_bad) begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                        busy_d    = 1'b0;
                        s_ready_d = 1'b0;
                        cs_d      = 1'b0;
                    end else begin
                        state_d    = S_RECV;
                        len_d      = load_len;
                        byte_idx_d = '0;
                        word_cnt_d = '0;
                        csum_d     = '0;
                        err_d      = 1'b0;
                        busy_d     = 1'b1;
                        cs_d       = 1'b1;
                        s_ready_d  = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = s_data;
                    csum_d = csum_q + s_data;
                    if (byte_idx_q == 2'd3) begin
                        // Word complete: drop ready for the single write cycle.
                        state_d    = S_WRITE;
                        s_ready_d  = 1'b0;
                        wen_d      = '1;
                        addr_d     = {word_cnt_q[MEM_ADDR_WTH-3:0], 2'b00};
                        byte_idx_d = '0;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_inc;
                byte_idx_d = '0;
                s_ready_d  = 1'b1;
                state_d    = (word_cnt_inc == len_q) ? S_CSUM : S_RECV;
            end
            S_CSUM: begin
                if (accept) begin
                    // Release the ITCM port either way; only a match frees the core.
                    s_ready_d = 1'b0;
                    cs_d      = 1'b0;
                    busy_d    = 1'b0;
                    if (s_data == csum_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign s_ready    = s_ready_q;
    assign itcm_cs    = cs_q;
    assign itcm_addr  = addr_q;
    assign itcm_wen   = wen_q;
    assign itcm_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_itcm_boot_loader.sv
// tb/tb_itcm_boot_loader.sv - directed self-checking bench for itcm_boot_loader
module tb_itcm_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] load_len = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        itcm_cs;
    logic [15:0] itcm_addr;
    logic [3:0]  itcm_wen;
    logic [31:0] itcm_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_wen[$];

    itcm_boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_len   (load_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .itcm_cs    (itcm_cs),
        .itcm_addr  (itcm_addr),
        .itcm_wen   (itcm_wen),
        .itcm_wdata (itcm_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Record every ITCM write cycle.
    always @(negedge clk) begin
        if (itcm_wen !== 4'h0) begin
            wr_addr.push_back(itcm_addr);
            wr_data.push_back(itcm_wdata);
            wr_wen.push_back(itcm_wen);
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_wen.delete();
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic pulse_start(input logic [15:0] len);
        start    = 1'b1;
        load_len = len;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL send_byte_timeout: s_ready=%0b required=1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({s_ready, itcm_cs, itcm_wen, itcm_addr, itcm_wdata, cpu_rst, busy, done, err}
            !== {1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%0b cs=%0b wen=%h addr=%h wd=%h crst=%0b busy=%0b done=%0b err=%0b required 0 0 0 0 0 1 0 0 0",
                     s_ready, itcm_cs, itcm_wen, itcm_addr, itcm_wdata, cpu_rst, busy, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err, cpu_rst} !== 4'b0001) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy/done/err/crst=%b required 0001", {busy, done, err, cpu_rst});
        end
    endtask

    task automatic test_single_word();
        clear_log();
        pulse_start(16'd1);
        n_cmp++;
        if ({busy, itcm_cs, s_ready, cpu_rst} !== 4'b1111) begin
            n_fail++;
            $display("FAIL t1_start: busy/cs/rdy/crst=%b required 1111", {busy, itcm_cs, s_ready, cpu_rst});
        end
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        n_cmp++;
        if ({itcm_wen, itcm_addr, itcm_wdata, s_ready} !== {4'hF, 16'h0000, 32'h12345678, 1'b0}) begin
            n_fail++;
            $display("FAIL t1_write_cycle: wen=%h addr=%h wd=%h rdy=%0b required F 0000 12345678 0",
                     itcm_wen, itcm_addr, itcm_wdata, s_ready);
        end
        send_byte(8'h14, 0);
        n_cmp++;
        if ({done, err, cpu_rst, busy, itcm_cs, s_ready} !== 6'b100000) begin
            n_fail++;
            $display("FAIL t1_done: done/err/crst/busy/cs/rdy=%b required 100000",
                     {done, err, cpu_rst, busy, itcm_cs, s_ready});
        end
        n_cmp++;
        if (wr_addr.size() != 1 || wr_data[0] !== 32'h12345678 || wr_wen[0] !== 4'hF) begin
            n_fail++;
            $display("FAIL t1_write_log: count=%0d required 1 word 12345678 wen F", wr_addr.size());
        end
    endtask

    task automatic test_two_words_restart();
        clear_log();
        pulse_start(16'd2);
        n_cmp++;
        if ({cpu_rst, done, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL t2_restart_from_done: crst/done/busy=%b required 101", {cpu_rst, done, busy});
        end
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
        send_byte(8'h24, 0);
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_done: done=%0b err=%0b crst=%0b required 1 0 0", done, err, cpu_rst);
        end
        n_cmp++;
        if (wr_addr.size() != 2) begin
            n_fail++;
            $display("FAIL t2_write_count: %0d required 2", wr_addr.size());
        end else begin
            n_cmp++;
            if (wr_addr[0] !== 16'h0000 || wr_data[0] !== 32'h04030201 ||
                wr_addr[1] !== 16'h0004 || wr_data[1] !== 32'h08070605) begin
                n_fail++;
                $display("FAIL t2_write_data: %h@%h %h@%h required 04030201@0000 08070605@0004",
                         wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        pulse_start(16'd1);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'h15, 0);
        n_cmp++;
        if ({err, done, cpu_rst, busy, itcm_cs} !== 5'b10100) begin
            n_fail++;
            $display("FAIL t3_err: err/done/crst/busy/cs=%b required 10100", {err, done, cpu_rst, busy, itcm_cs});
        end
        n_cmp++;
        if (wr_addr.size() != 1 || wr_data[0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL t3_write_log: count=%0d required 1 word 12345678", wr_addr.size());
        end
    endtask

    task automatic test_bad_length();
        clear_log();
        pulse_start(16'd0);
        n_cmp++;
        if ({err, busy, s_ready, cpu_rst} !== 4'b1001) begin
            n_fail++;
            $display("FAIL t4_len0: err/busy/rdy/crst=%b required 1001", {err, busy, s_ready, cpu_rst});
        end
        pulse_start(16'h4001);
        n_cmp++;
        if ({err, busy, s_ready, cpu_rst} !== 4'b1001) begin
            n_fail++;
            $display("FAIL t4_len4001: err/busy/rdy/crst=%b required 1001", {err, busy, s_ready, cpu_rst});
        end
        pulse_start(16'h4000);
        n_cmp++;
        if ({err, busy, s_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL t4_len4000_accepted: err/busy/rdy=%b required 011", {err, busy, s_ready});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL t4_no_writes: count=%0d required 0", wr_addr.size());
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_gaps_and_ignored_start();
        logic [7:0] bytes [8];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_log();
        pulse_start(16'd2);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) pulse_start(16'd5);
            send_byte(bytes[i], int'($urandom_range(0, 3)));
        end
        send_byte(8'h64, 2);
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_done: done=%0b err=%0b crst=%0b required 1 0 0", done, err, cpu_rst);
        end
        n_cmp++;
        if (wr_addr.size() != 2) begin
            n_fail++;
            $display("FAIL t5_write_count: %0d required 2", wr_addr.size());
        end else begin
            n_cmp++;
            if (wr_addr[0] !== 16'h0000 || wr_data[0] !== 32'h44332211 ||
                wr_addr[1] !== 16'h0004 || wr_data[1] !== 32'h88776655) begin
                n_fail++;
                $display("FAIL t5_write_data: %h@%h %h@%h required 44332211@0000 88776655@0004",
                         wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
            end
        end
    endtask

    task automatic test_mid_load_reset();
        clear_log();
        pulse_start(16'd1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({s_ready, itcm_cs, itcm_wen, itcm_addr, itcm_wdata, cpu_rst, busy, done, err}
            !== {1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL t6_async_reset: rdy=%0b cs=%0b wen=%h addr=%h wd=%h crst=%0b busy=%0b done=%0b err=%0b required 0 0 0 0 0 1 0 0 0",
                     s_ready, itcm_cs, itcm_wen, itcm_addr, itcm_wdata, cpu_rst, busy, done, err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        pulse_start(16'd1);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        // EF+BE+AD+DE = 0x338 -> 0x38
        send_byte(8'h38, 0);
        n_cmp++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || wr_addr.size() != 1 || wr_data[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL t6_reload: done=%0b crst=%0b writes=%0d required 1 0 1 (DEADBEEF)",
                     done, cpu_rst, wr_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words_restart();
        test_bad_checksum();
        test_bad_length();
        test_gaps_and_ignored_start();
        test_mid_load_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
